regfile_mp: RTL and testbench

Parametrised dual-write, dual-read register file. It is the next-generation CPU register file for the datapath. Beyond basic storage it adds:
- configurable width and depth;
- a second write port with defined collision priority;
- optional write-to-read bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard with a registered busy count, used by the issue logic to stall on pending results.

---
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: write, read and scoreboard signals.
// The issue/datapath side uses master and the register file uses slave.
interface regfile_mp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rout1;
    logic [DATA_W-1:0] rout2;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rbusy1;
    logic              rbusy2;
    logic [ADDR_W:0]   busy_cnt;
    logic              wconf;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output raddr1, raddr2, rsv_en, rsv_addr,
        input  rout1, rout2, rbusy1, rbusy2, busy_cnt, wconf
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  raddr1, raddr2, rsv_en, rsv_addr,
        output rout1, rout2, rbusy1, rbusy2, busy_cnt, wconf
    );
endinterface

// File: rtl/regfile_mp.sv
// Dual-write, dual-read register file with write bypass, optional zero
// register and a per-register busy scoreboard for issue stalls.
module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic       clk,
    input  logic       areset_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [ADDR_W:0]   busy_cnt_r;
    logic              wconf_r;
    logic              we0_s;
    logic              we1_s;
    logic              rsv_s;
    logic              wconf_nxt_s;
    logic [DATA_W-1:0] rout1_s;
    logic [DATA_W-1:0] rout2_s;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG == 1'b1) && (addr == {ADDR_W{1'b0}});
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Port 1 bypass is checked first so it wins when both ports hit the read address.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              we0_i,
        input logic [ADDR_W-1:0] wa0_i,
        input logic [DATA_W-1:0] wd0_i,
        input logic              we1_i,
        input logic [ADDR_W-1:0] wa1_i,
        input logic [DATA_W-1:0] wd1_i
    );
        logic [DATA_W-1:0] val;
        if (is_zero_addr(ra)) begin
            val = {DATA_W{1'b0}};
        end else if ((BYPASS == 1'b1) && we1_i && (wa1_i == ra)) begin
            val = wd1_i;
        end else if ((BYPASS == 1'b1) && we0_i && (wa0_i == ra)) begin
            val = wd0_i;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Effective enables and next scoreboard state; reserve beats a same-cycle write.
    always_comb begin
        we0_s       = bus.we0 & ~is_zero_addr(bus.waddr0);
        we1_s       = bus.we1 & ~is_zero_addr(bus.waddr1);
        rsv_s       = bus.rsv_en & ~is_zero_addr(bus.rsv_addr);
        wconf_nxt_s = we0_s & we1_s & (bus.waddr0 == bus.waddr1);
        busy_nxt_s  = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_s && (bus.rsv_addr == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if ((we0_s && (bus.waddr0 == ADDR_W'(i))) ||
                         (we1_s && (bus.waddr1 == ADDR_W'(i)))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Combinational read ports with optional write bypass.
    always_comb begin
        rout1_s = read_port(bus.raddr1, mem_r[bus.raddr1], we0_s, bus.waddr0,
                            bus.wdata0, we1_s, bus.waddr1, bus.wdata1);
        rout2_s = read_port(bus.raddr2, mem_r[bus.raddr2], we0_s, bus.waddr0,
                            bus.wdata0, we1_s, bus.waddr1, bus.wdata1);
    end

    // Storage array; port 1 data is kept when both ports hit the same register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we1_s && (bus.waddr1 == ADDR_W'(i))) begin
                    mem_r[i] <= bus.wdata1;
                end else if (we0_s && (bus.waddr0 == ADDR_W'(i))) begin
                    mem_r[i] <= bus.wdata0;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Scoreboard, busy count and write-collision pulse.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_cnt_r <= {(ADDR_W+1){1'b0}};
            wconf_r    <= 1'b0;
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
            wconf_r    <= wconf_nxt_s;
        end
    end

    assign bus.rout1    = rout1_s;
    assign bus.rout2    = rout2_s;
    assign bus.rbusy1   = busy_r[bus.raddr1];
    assign bus.rbusy2   = busy_r[bus.raddr2];
    assign bus.busy_cnt = busy_cnt_r;
    assign bus.wconf    = wconf_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: instance 0 default (bypass on), instance 1
// without bypass, instance 2 with the zero register; all share one stimulus.
module tb_regfile_mp;
    logic       clk;
    logic       areset_n;
    logic       we0, we1, rsv_en;
    logic [2:0] waddr0, waddr1, raddr1, raddr2, rsv_addr;
    logic [7:0] wdata0, wdata1;

    logic [7:0] rout1_s [3];
    logic [7:0] rout2_s [3];
    logic       rbusy1_s [3];
    logic       rbusy2_s [3];
    logic [3:0] cnt_s [3];
    logic       wconf_s [3];

    int errors = 0;
    int checks = 0;

    regfile_mp_if #(.DATA_W(8), .ADDR_W(3)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].we0      = we0;
        assign bus[g].waddr0   = waddr0;
        assign bus[g].wdata0   = wdata0;
        assign bus[g].we1      = we1;
        assign bus[g].waddr1   = waddr1;
        assign bus[g].wdata1   = wdata1;
        assign bus[g].raddr1   = raddr1;
        assign bus[g].raddr2   = raddr2;
        assign bus[g].rsv_en   = rsv_en;
        assign bus[g].rsv_addr = rsv_addr;

        regfile_mp #(
            .DATA_W(8), .ADDR_W(3),
            .BYPASS((g == 1) ? 1'b0 : 1'b1),
            .ZERO_REG((g == 2) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk(clk),
            .areset_n(areset_n),
            .bus(bus[g])
        );

        assign rout1_s[g]  = bus[g].rout1;
        assign rout2_s[g]  = bus[g].rout2;
        assign rbusy1_s[g] = bus[g].rbusy1;
        assign rbusy2_s[g] = bus[g].rbusy2;
        assign cnt_s[g]    = bus[g].busy_cnt;
        assign wconf_s[g]  = bus[g].wconf;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we0;
        logic [2:0] wa0;
        logic [7:0] wd0;
        logic       we1;
        logic [2:0] wa1;
        logic [7:0] wd1;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic       rsv;
        logic [2:0] rsa;
        logic [7:0] e_r1;
        logic [7:0] e_r2;
        logic       e_b1;
        logic       e_b2;
        logic [3:0] e_cnt;
        logic       e_wc;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = 3'd0; wdata0 = 8'h00;
        we1 = 1'b0; waddr1 = 3'd0; wdata1 = 8'h00;
        rsv_en = 1'b0; rsv_addr = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs apply 1 after an edge; outputs reflect state from earlier rows plus bypass.
        vt[0]  = '{1'b1,3'd3,8'hAA, 1'b1,3'd5,8'h55, 3'd3,3'd5, 1'b0,3'd0, 8'hAA,8'h55, 1'b0,1'b0, 4'd0,1'b0};
        vt[1]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd3,3'd5, 1'b0,3'd0, 8'hAA,8'h55, 1'b0,1'b0, 4'd0,1'b0};
        vt[2]  = '{1'b1,3'd2,8'h11, 1'b1,3'd2,8'h22, 3'd2,3'd3, 1'b0,3'd0, 8'h22,8'hAA, 1'b0,1'b0, 4'd0,1'b0};
        vt[3]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd2,3'd5, 1'b0,3'd0, 8'h22,8'h55, 1'b0,1'b0, 4'd0,1'b1};
        vt[4]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd2,3'd2, 1'b0,3'd0, 8'h22,8'h22, 1'b0,1'b0, 4'd0,1'b0};
        vt[5]  = '{1'b1,3'd4,8'h7E, 1'b0,3'd0,8'h00, 3'd4,3'd1, 1'b0,3'd0, 8'h7E,8'h00, 1'b0,1'b0, 4'd0,1'b0};
        vt[6]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd1,3'd6, 1'b1,3'd1, 8'h00,8'h00, 1'b0,1'b0, 4'd0,1'b0};
        vt[7]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd1,3'd6, 1'b1,3'd6, 8'h00,8'h00, 1'b1,1'b0, 4'd1,1'b0};
        vt[8]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd1,3'd6, 1'b1,3'd1, 8'h00,8'h00, 1'b1,1'b1, 4'd2,1'b0};
        vt[9]  = '{1'b1,3'd1,8'h33, 1'b0,3'd0,8'h00, 3'd1,3'd6, 1'b1,3'd1, 8'h33,8'h00, 1'b1,1'b1, 4'd2,1'b0};
        vt[10] = '{1'b0,3'd0,8'h00, 1'b1,3'd6,8'h66, 3'd1,3'd6, 1'b0,3'd0, 8'h33,8'h66, 1'b1,1'b1, 4'd2,1'b0};
        vt[11] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd1,3'd6, 1'b0,3'd0, 8'h33,8'h66, 1'b1,1'b0, 4'd1,1'b0};
        vt[12] = '{1'b0,3'd0,8'h00, 1'b1,3'd1,8'h44, 3'd4,3'd1, 1'b0,3'd0, 8'h7E,8'h44, 1'b0,1'b1, 4'd1,1'b0};
        vt[13] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd1,3'd1, 1'b0,3'd0, 8'h44,8'h44, 1'b0,1'b0, 4'd0,1'b0};

        // Write attempted while reset is held must be discarded.
        idle();
        areset_n = 1'b0;
        we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'hAA;
        raddr1 = 3'd3; raddr2 = 3'd0;
        step();
        chk("rst_nobypass_rout1", rout1_s[1], 8'h00);
        chk("rst_busy_cnt", cnt_s[0], 4'd0);
        chk("rst_wconf", wconf_s[0], 1'b0);
        chk("rst_rbusy1", rbusy1_s[0], 1'b0);
        we0 = 1'b0;
        #1;
        chk("rst_mem3", rout1_s[0], 8'h00);
        areset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
            we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
            raddr1 = vt[i].ra1; raddr2 = vt[i].ra2;
            rsv_en = vt[i].rsv; rsv_addr = vt[i].rsa;
            #2;
            chk($sformatf("v%0d_rout1", i), rout1_s[0], vt[i].e_r1);
            chk($sformatf("v%0d_rout2", i), rout2_s[0], vt[i].e_r2);
            chk($sformatf("v%0d_rbusy1", i), rbusy1_s[0], vt[i].e_b1);
            chk($sformatf("v%0d_rbusy2", i), rbusy2_s[0], vt[i].e_b2);
            chk($sformatf("v%0d_busy_cnt", i), cnt_s[0], vt[i].e_cnt);
            chk($sformatf("v%0d_wconf", i), wconf_s[0], vt[i].e_wc);
            chk($sformatf("v%0d_zr_rout1", i), rout1_s[2], vt[i].e_r1);
            chk($sformatf("v%0d_zr_busy_cnt", i), cnt_s[2], vt[i].e_cnt);
            if (i == 5) begin
                chk("nobypass_rout1_before_edge", rout1_s[1], 8'h00);
            end
            step();
        end
        idle();

        // Zero register: colliding writes and a reserve to r0.
        we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'hFF;
        we1 = 1'b1; waddr1 = 3'd0; wdata1 = 8'hEE;
        rsv_en = 1'b1; rsv_addr = 3'd0;
        raddr1 = 3'd0; raddr2 = 3'd0;
        #2;
        chk("zr_rout1_bypass", rout1_s[2], 8'h00);
        chk("zr_rbusy1_pre", rbusy1_s[2], 1'b0);
        chk("r0_bypass_port1", rout1_s[0], 8'hEE);
        step();
        idle();
        #1;
        chk("r0_stored", rout1_s[0], 8'hEE);
        chk("r0_wconf", wconf_s[0], 1'b1);
        chk("r0_busy_cnt", cnt_s[0], 4'd1);
        chk("r0_rbusy1", rbusy1_s[0], 1'b1);
        chk("zr_rout1", rout1_s[2], 8'h00);
        chk("zr_rbusy1", rbusy1_s[2], 1'b0);
        chk("zr_busy_cnt", cnt_s[2], 4'd0);
        chk("zr_wconf", wconf_s[2], 1'b0);

        // No-bypass instance shows the stored value until after the edge.
        we0 = 1'b1; waddr0 = 3'd4; wdata0 = 8'h5A;
        raddr1 = 3'd4;
        #1;
        chk("nb_rout1_old", rout1_s[1], 8'h7E);
        chk("bp_rout1_new", rout1_s[0], 8'h5A);
        step();
        idle();
        #1;
        chk("nb_rout1_after", rout1_s[1], 8'h5A);
        chk("wconf_cleared", wconf_s[0], 1'b0);
        step();

        // Reserve every register; r0 is already busy in instance 0, never in instance 2.
        for (int i = 0; i < 8; i++) begin
            rsv_en = 1'b1; rsv_addr = 3'(i);
            step();
            chk($sformatf("fill%0d_busy_cnt", i), cnt_s[0], 32'(i + 1));
            chk($sformatf("fill%0d_zr_busy_cnt", i), cnt_s[2], 32'(i));
        end
        idle();

        // Asynchronous reset between edges clears everything immediately.
        #2;
        areset_n = 1'b0;
        #1;
        chk("arst_busy_cnt", cnt_s[0], 4'd0);
        for (int i = 0; i < 4; i++) begin
            raddr1 = 3'(i); raddr2 = 3'(i + 4);
            #1;
            chk($sformatf("arst_rout1_r%0d", i), rout1_s[0], 8'h00);
            chk($sformatf("arst_rout2_r%0d", i + 4), rout2_s[0], 8'h00);
            chk($sformatf("arst_rbusy1_r%0d", i), rbusy1_s[0], 1'b0);
            chk($sformatf("arst_rbusy2_r%0d", i + 4), rbusy2_s[0], 1'b0);
        end
        areset_n = 1'b1;
        raddr1 = 3'd3; raddr2 = 3'd5;
        step();
        chk("post_rst_r3", rout1_s[0], 8'h00);
        chk("post_rst_r5", rout2_s[0], 8'h00);
        chk("post_rst_cnt", cnt_s[0], 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
